// File: rtl/tap_driver_pkg.sv
// Shared TAP driver definitions: controller state encoding, default widths
// and a sizing helper used for the per-state cycle counter.
package tap_driver_pkg;

  localparam int DEF_BYTE_WIDTH   = 8;
  localparam int DEF_RESULT_WIDTH = 16;

  typedef enum logic [3:0] {
    ST_TLR    = 4'd0,
    ST_IDLE   = 4'd1,
    ST_CAP    = 4'd2,
    ST_SHIFT  = 4'd3,
    ST_UPD    = 4'd4,
    ST_DRAIN  = 4'd5,
    ST_RCAP   = 4'd6,
    ST_RSHIFT = 4'd7,
    ST_RUPD   = 4'd8,
    ST_DONE   = 4'd9
  } tap_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m_ab;
    int m_cd;
    m_ab = (a > b) ? a : b;
    m_cd = (c > d) ? c : d;
    return (m_ab > m_cd) ? m_ab : m_cd;
  endfunction

endpackage

// File: rtl/tap_driver_shifter.sv
// Shared data register: parallel load then serial out from bit 0, and serial
// in at the top bit, both shifting right.
module tap_shifter
  import tap_driver_pkg::*;
#(
  parameter int WIDTH = DEF_RESULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] par
);

  logic [WIDTH-1:0] sr_r;

  // Shift register: load has priority over shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sr_r <= load_data;
    end else if (shift_en) begin
      sr_r <= {sin, sr_r[WIDTH-1:1]};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign sout = sr_r[0];
  assign par  = sr_r;

endmodule

// File: rtl/tap_driver.sv
// Drives a user DR over TAP strobes: shifts each inbound byte out on tdi,
// then after a drain period shifts back a result word from tdo.
module tap_driver
  import tap_driver_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_BYTE_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int TLR_CYCLES   = 5,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  output logic                    tdi,
  input  logic                    tdo,
  output logic                    test_logic_reset,
  output logic                    run_test_idle,
  output logic                    ir_is_user,
  output logic                    capture_dr,
  output logic                    shift_dr,
  output logic                    update_dr,
  output logic                    result_valid,
  output logic [RESULT_WIDTH-1:0] result_data
);

  localparam int SW = (DATA_WIDTH > RESULT_WIDTH) ? DATA_WIDTH : RESULT_WIDTH;
  localparam int CW = $clog2(max4(DATA_WIDTH, RESULT_WIDTH, DRAIN_CYCLES, TLR_CYCLES) + 1);

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] TLR_LAST   = CW'(TLR_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RES_LAST   = CW'(RESULT_WIDTH - 1);

  tap_state_e    state_r;
  tap_state_e    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          last_r;
  logic          hs_s;
  logic          sh_shift_s;
  logic          sh_sout_s;
  logic [SW-1:0] sh_par_s;
  logic [SW-1:0] sh_load_data_s;

  assign sh_load_data_s = SW'(s_data);
  // Byte bits leave one edge ahead of the SHIFT cycle that shows them on tdi.
  assign sh_shift_s = (state_nxt_s == ST_SHIFT) || (state_r == ST_RSHIFT);

  tap_shifter #(.WIDTH(SW)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hs_s),
    .load_data (sh_load_data_s),
    .shift_en  (sh_shift_s),
    .sin       (tdo),
    .sout      (sh_sout_s),
    .par       (sh_par_s)
  );

  // Next-state and per-state cycle counter; counter only runs in timed states.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = CNT_ZERO;
    hs_s        = 1'b0;
    case (state_r)
      ST_TLR: begin
        if (cnt_r == TLR_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (s_valid) begin
          hs_s        = 1'b1;
          state_nxt_s = ST_CAP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAP: state_nxt_s = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_r == DATA_LAST) begin
          state_nxt_s = ST_UPD;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_UPD: begin
        if (last_r) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_RCAP;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RCAP: state_nxt_s = ST_RSHIFT;
      ST_RSHIFT: begin
        if (cnt_r == RES_LAST) begin
          state_nxt_s = ST_RUPD;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUPD: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_TLR;
    endcase
  end

  // State, counter and registered outputs decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_TLR;
      cnt_r            <= CNT_ZERO;
      last_r           <= 1'b0;
      test_logic_reset <= 1'b1;
      run_test_idle    <= 1'b0;
      ir_is_user       <= 1'b0;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      s_ready          <= 1'b0;
      tdi              <= 1'b0;
      result_valid     <= 1'b0;
      result_data      <= {RESULT_WIDTH{1'b0}};
    end else begin
      state_r          <= state_nxt_s;
      cnt_r            <= cnt_nxt_s;
      last_r           <= hs_s ? s_last : last_r;
      test_logic_reset <= (state_nxt_s == ST_TLR);
      run_test_idle    <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DRAIN) ||
                          (state_nxt_s == ST_DONE);
      ir_is_user       <= (state_nxt_s != ST_TLR);
      capture_dr       <= (state_nxt_s == ST_CAP) || (state_nxt_s == ST_RCAP);
      shift_dr         <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_RSHIFT);
      update_dr        <= (state_nxt_s == ST_UPD) || (state_nxt_s == ST_RUPD);
      s_ready          <= (state_nxt_s == ST_IDLE);
      tdi              <= (state_nxt_s == ST_SHIFT) ? sh_sout_s : 1'b0;
      result_valid     <= (state_r == ST_RUPD);
      result_data      <= (state_r == ST_RUPD) ? sh_par_s[SW-1 -: RESULT_WIDTH] : result_data;
    end
  end

endmodule

// File: tb/tb_tap_driver.sv
// Randomized bench for tap_driver: a transaction-level model expands each
// accepted byte / readout into the expected per-cycle strobe trace.
module tb_tap_driver;

  localparam int DW   = 8;
  localparam int RW   = 16;
  localparam int TLRC = 5;
  localparam int DRC  = 16;

  localparam logic [4:0] S_TLR = 5'b10000;
  localparam logic [4:0] S_RTI = 5'b01000;
  localparam logic [4:0] S_CAP = 5'b00100;
  localparam logic [4:0] S_SHF = 5'b00010;
  localparam logic [4:0] S_UPD = 5'b00001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          tdi;
  logic          tdo = 1'b0;
  logic          test_logic_reset, run_test_idle, ir_is_user;
  logic          capture_dr, shift_dr, update_dr;
  logic          result_valid;
  logic [RW-1:0] result_data;

  always #5 clk = ~clk;

  tap_driver #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TLR_CYCLES(TLRC), .DRAIN_CYCLES(DRC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .tdi(tdi), .tdo(tdo),
    .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
    .ir_is_user(ir_is_user), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .result_valid(result_valid), .result_data(result_data)
  );

  typedef struct {
    logic [4:0]    strb;
    logic          tdi_b;
    logic          rdy;
    logic          drv;
    logic          tdo_b;
    logic          rv;
    logic [RW-1:0] rd;
    int            sidx;
  } exp_t;

  exp_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            rst_cnt = 0;
  int            done_cyc = 0;
  logic          file_done = 1'b0;
  logic [RW-1:0] exp_rdata = '0;
  logic [RW-1:0] word = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] strb, input logic tdi_b, input logic rdy,
                              input logic drv, input logic tdo_b, input logic rv,
                              input logic [RW-1:0] rd, input int sidx);
    exp_t e;
    e.strb = strb; e.tdi_b = tdi_b; e.rdy = rdy; e.drv = drv;
    e.tdo_b = tdo_b; e.rv = rv; e.rd = rd; e.sidx = sidx;
    return e;
  endfunction

  // Reset held for h edges: h-1 held cycles plus TLRC cycles after release.
  task automatic push_reset(input int h);
    exp_q.delete();
    exp_rdata = '0;
    file_done = 1'b0;
    done_cyc  = 0;
    rst_cnt   = h;
    for (int i = 0; i < h - 1 + TLRC; i++) exp_q.push_back(mk(S_TLR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1));
  endtask

  task automatic push_byte(input logic [DW-1:0] d, input logic last);
    exp_q.push_back(mk(S_CAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1));
    for (int k = 0; k < DW; k++) exp_q.push_back(mk(S_SHF, d[k], 1'b0, 1'b0, 1'b0, 1'b0, '0, k));
    exp_q.push_back(mk(S_UPD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1));
    if (last) begin
      for (int i = 0; i < DRC; i++) exp_q.push_back(mk(S_RTI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1));
      exp_q.push_back(mk(S_CAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1));
      for (int k = 0; k < RW; k++) exp_q.push_back(mk(S_SHF, 1'b0, 1'b0, 1'b1, word[k], 1'b0, '0, -1));
      exp_q.push_back(mk(S_UPD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1));
      exp_q.push_back(mk(S_RTI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, word, -1));
    end
  endtask

  initial begin
    exp_t          e;
    int            phase;
    int            nbytes;
    int            sent;
    logic          finished;
    logic          want;
    logic [DW-1:0] d;

    phase = 0; nbytes = 3; sent = 0; finished = 1'b0;
    word = 16'hBEEF;
    push_reset(3);
    e = mk(S_TLR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      // Drive inputs for the coming edge from the currently expected cycle.
      if (rst_cnt > 0) begin
        rst_n = 1'b0;
        rst_cnt--;
      end else begin
        rst_n = 1'b1;
      end
      tdo     = e.drv ? e.tdo_b : 1'($urandom);
      s_data  = DW'($urandom);
      s_last  = 1'($urandom);
      s_valid = (phase == 0) ? 1'b1 : 1'($urandom);
      if (rst_n && e.strb == S_RTI && e.rdy) begin
        want = (phase == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
        if (want && sent < nbytes) begin
          d = (phase == 0 && sent == 0) ? 8'hA5 : DW'($urandom);
          s_valid = 1'b1;
          s_data  = d;
          s_last  = (sent == nbytes - 1);
          push_byte(d, sent == nbytes - 1);
          sent++;
        end else begin
          s_valid = 1'b0;
        end
      end

      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(S_RTI, 1'b0, !file_done, 1'b0, 1'b0, 1'b0, '0, -1);
      if (e.rv) begin
        exp_rdata = e.rd;
        file_done = 1'b1;
      end
      check_val("strobes", {27'd0, test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr}, {27'd0, e.strb});
      check_val("ir_is_user", {31'd0, ir_is_user}, {31'd0, !e.strb[4]});
      check_val("tdi", {31'd0, tdi}, {31'd0, e.tdi_b});
      check_val("s_ready", {31'd0, s_ready}, {31'd0, e.rdy});
      check_val("result_valid", {31'd0, result_valid}, {31'd0, e.rv});
      check_val("result_data", {16'd0, result_data}, {16'd0, exp_rdata});

      if (file_done) done_cyc++;
      if (phase == 0 && done_cyc == 6) begin
        push_reset(1);
        phase = 1; nbytes = 3; sent = 0; word = RW'($urandom);
      end else if (phase == 1 && sent == 2 && e.sidx == 3) begin
        push_reset(2);
        phase = 2; nbytes = $urandom_range(4, 1); sent = 0; word = RW'($urandom);
      end else if (phase == 2 && done_cyc == 6) begin
        finished = 1'b1;
      end
    end

    if (!finished) check_val("timeout", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
